// File: rtl/gb_cpu_pkg.sv
// Shared SM83 core definitions: fetch FSM states, instruction packet layout,
// and the opcode length/legality helpers shared between fetch and decode.
package gb_cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_B1,
        FETCH_B2,
        HOLD
    } fetch_state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  cb_op;
        logic        cb;
        logic [15:0] imm;
        logic [1:0]  len;
        logic [15:0] pc;
        logic        illegal;
    } fetch_pkt_t;

    localparam logic [7:0] CB_PREFIX = 8'hCB;

    localparam int unsigned N_ILLEGAL = 11;
    localparam logic [8*N_ILLEGAL-1:0] ILLEGAL_OPS = {
        8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
        8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD
    };

    function automatic logic is_illegal_op(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < N_ILLEGAL; i++) begin
            if (op == ILLEGAL_OPS[8*i +: 8]) hit = 1'b1;
        end
        return hit;
    endfunction

    // Illegal opcodes fall through to length 1 so the fetcher never stalls on them.
    function automatic logic [1:0] instr_len(input logic [7:0] op);
        logic [1:0] len;
        case (op)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8, 8'hCB:
                len = 2'd2;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
            8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
                len = 2'd3;
            default:
                len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/instr_len_lut.sv
// Combinational opcode classifier: instruction length and illegal-opcode flag.
module instr_len_lut
    import gb_cpu_pkg::*;
(
    input  logic [7:0] op_i,
    output logic [1:0] len_o,
    output logic       illegal_o
);

    always_comb begin
        len_o     = instr_len(op_i);
        illegal_o = is_illegal_op(op_i);
    end

endmodule

// File: rtl/instr_fetch.sv
// SM83 instruction fetch: reads opcode and operand bytes at PC, assembles one
// packet per instruction and hands it to decode over a valid/ready handshake.
module instr_fetch
    import gb_cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    input  logic        redir_valid,
    input  logic [15:0] redir_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_opcode,
    output logic [7:0]  out_cb_op,
    output logic        out_cb,
    output logic [15:0] out_imm,
    output logic [1:0]  out_len,
    output logic [15:0] out_pc,
    output logic        out_illegal
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    fetch_pkt_t   pkt_q, pkt_d;

    logic [1:0]   lut_len;
    logic         lut_illegal;

    instr_len_lut u_len_lut (
        .op_i      (mem_rdata),
        .len_o     (lut_len),
        .illegal_o (lut_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_OP;
            pc_q    <= RESET_PC;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pkt_d   = pkt_q;

        // A redirect wins over any in-flight byte: its data is dropped and pc is not bumped.
        if (redir_valid) begin
            state_d = FETCH_OP;
            pc_d    = redir_pc;
        end else begin
            case (state_q)
                FETCH_OP: begin
                    if (mem_ready) begin
                        pkt_d         = '0;
                        pkt_d.opcode  = mem_rdata;
                        pkt_d.pc      = pc_q;
                        pkt_d.len     = lut_len;
                        pkt_d.illegal = lut_illegal;
                        pc_d          = pc_q + 16'd1;
                        state_d       = (lut_len == 2'd1) ? HOLD : FETCH_B1;
                    end
                end
                FETCH_B1: begin
                    if (mem_ready) begin
                        if (pkt_q.opcode == CB_PREFIX) begin
                            pkt_d.cb_op = mem_rdata;
                            pkt_d.cb    = 1'b1;
                        end else begin
                            pkt_d.imm[7:0] = mem_rdata;
                        end
                        pc_d    = pc_q + 16'd1;
                        state_d = (pkt_q.len == 2'd3) ? FETCH_B2 : HOLD;
                    end
                end
                FETCH_B2: begin
                    if (mem_ready) begin
                        pkt_d.imm[15:8] = mem_rdata;
                        pc_d            = pc_q + 16'd1;
                        state_d         = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) state_d = FETCH_OP;
                end
                default: state_d = FETCH_OP;
            endcase
        end
    end

    assign mem_addr    = pc_q;
    assign mem_rd      = (state_q != HOLD);
    assign out_valid   = (state_q == HOLD);
    assign out_opcode  = pkt_q.opcode;
    assign out_cb_op   = pkt_q.cb_op;
    assign out_cb      = pkt_q.cb;
    assign out_imm     = pkt_q.imm;
    assign out_len     = pkt_q.len;
    assign out_pc      = pkt_q.pc;
    assign out_illegal = pkt_q.illegal;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a flat 64 KiB memory model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode;
    logic [7:0]  out_cb_op;
    logic        out_cb;
    logic [15:0] out_imm;
    logic [1:0]  out_len;
    logic [15:0] out_pc;
    logic        out_illegal;

    logic [7:0]  mem [0:65535];
    int          n_chk;
    int          n_fail;
    int          xfer_cnt;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_cb_op   (out_cb_op),
        .out_cb      (out_cb),
        .out_imm     (out_imm),
        .out_len     (out_len),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_ready ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic start_at(input logic [15:0] a);
        @(negedge clk);
        redir_valid = 1'b1;
        redir_pc    = a;
        mem_ready   = 1'b1;
        out_ready   = 1'b0;
        @(negedge clk);
        redir_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_ready = 1'b0; out_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
        repeat (2) @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_chk++; if ({out_opcode, out_cb_op, out_cb, out_imm, out_len, out_pc, out_illegal} !== '0)
            begin n_fail++; $display("FAIL rst_packet got op=%h imm=%h len=%0d pc=%h want all 0", out_opcode, out_imm, out_len, out_pc); end
        rst = 1'b0; mem_ready = 1'b1; out_ready = 1'b1;
        n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_fetch got rd=%b addr=%h want 1 0000", mem_rd, mem_addr); end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1 || out_opcode !== 8'h00 || out_len !== 2'd1 || out_pc !== 16'h0000)
            begin n_fail++; $display("FAIL rst_nop got v=%b op=%h len=%0d pc=%h want 1 00 1 0000", out_valid, out_opcode, out_len, out_pc); end
        n_chk++; if (mem_addr !== 16'h0001) begin n_fail++; $display("FAIL rst_next_addr got %h want 0001", mem_addr); end
    endtask

    task automatic test_jp;
        int cyc;
        mem[16'h0100] = 8'hC3; mem[16'h0101] = 8'h50; mem[16'h0102] = 8'h01;
        start_at(16'h0100);
        n_chk++; if (mem_addr !== 16'h0100) begin n_fail++; $display("FAIL jp_redir_addr got %h want 0100", mem_addr); end
        wait_valid(cyc);
        n_chk++; if (cyc !== 3) begin n_fail++; $display("FAIL jp_latency got %0d want 3", cyc); end
        n_chk++; if (out_opcode !== 8'hC3 || out_imm !== 16'h0150 || out_len !== 2'd3 || out_pc !== 16'h0100)
            begin n_fail++; $display("FAIL jp_packet got op=%h imm=%h len=%0d pc=%h want C3 0150 3 0100", out_opcode, out_imm, out_len, out_pc); end
        n_chk++; if (out_cb !== 1'b0 || out_cb_op !== 8'h00 || out_illegal !== 1'b0)
            begin n_fail++; $display("FAIL jp_flags got cb=%b cbop=%h ill=%b want 0 00 0", out_cb, out_cb_op, out_illegal); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || mem_addr !== 16'h0103 || mem_rd !== 1'b1)
            begin n_fail++; $display("FAIL jp_next got v=%b addr=%h rd=%b want 0 0103 1", out_valid, mem_addr, mem_rd); end
    endtask

    task automatic test_cb;
        int cyc;
        mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h37;
        start_at(16'h0200);
        wait_valid(cyc);
        n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL cb_latency got %0d want 2", cyc); end
        n_chk++; if (out_cb !== 1'b1 || out_opcode !== 8'hCB || out_cb_op !== 8'h37 || out_imm !== 16'h0000 || out_len !== 2'd2)
            begin n_fail++; $display("FAIL cb_packet got cb=%b op=%h cbop=%h imm=%h len=%0d want 1 CB 37 0000 2", out_cb, out_opcode, out_cb_op, out_imm, out_len); end
    endtask

    task automatic test_stall_and_hold;
        int x0;
        mem[16'h0300] = 8'h06; mem[16'h0301] = 8'h5A;
        start_at(16'h0300);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (mem_addr !== 16'h0301 || out_valid !== 1'b0 || mem_rd !== 1'b1)
                begin n_fail++; $display("FAIL stall_hold_addr[%0d] got addr=%h v=%b rd=%b want 0301 0 1", i, mem_addr, out_valid, mem_rd); end
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1 || out_imm !== 16'h005A || out_len !== 2'd2)
            begin n_fail++; $display("FAIL stall_packet got v=%b imm=%h len=%0d want 1 005A 2", out_valid, out_imm, out_len); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++; if (out_valid !== 1'b1 || mem_rd !== 1'b0 || out_opcode !== 8'h06 || out_imm !== 16'h005A || out_pc !== 16'h0300)
                begin n_fail++; $display("FAIL hold_stable[%0d] got v=%b rd=%b op=%h imm=%h pc=%h want 1 0 06 005A 0300", i, out_valid, mem_rd, out_opcode, out_imm, out_pc); end
        end
        x0 = xfer_cnt;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_chk++; if (xfer_cnt - x0 !== 1 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL hold_release got xfers=%0d v=%b want 1 0", xfer_cnt - x0, out_valid); end
    endtask

    task automatic test_redirect;
        int cyc;
        mem[16'h0400] = 8'h21; mem[16'h0401] = 8'h34; mem[16'h0402] = 8'h12;
        mem[16'h0038] = 8'h00;
        start_at(16'h0400);
        @(negedge clk);
        redir_valid = 1'b1; redir_pc = 16'h0038; mem_ready = 1'b1;
        @(negedge clk);
        redir_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || mem_addr !== 16'h0038 || mem_rd !== 1'b1)
            begin n_fail++; $display("FAIL redir_addr got v=%b addr=%h rd=%b want 0 0038 1", out_valid, mem_addr, mem_rd); end
        wait_valid(cyc);
        n_chk++; if (cyc !== 1 || out_opcode !== 8'h00 || out_pc !== 16'h0038 || out_imm !== 16'h0000 || out_len !== 2'd1)
            begin n_fail++; $display("FAIL redir_packet got cyc=%0d op=%h pc=%h imm=%h len=%0d want 1 00 0038 0000 1", cyc, out_opcode, out_pc, out_imm, out_len); end
    endtask

    task automatic test_wrap;
        int cyc;
        mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h12;
        start_at(16'hFFFF);
        wait_valid(cyc);
        n_chk++; if (cyc !== 2 || out_opcode !== 8'h3E || out_imm !== 16'h0012 || out_pc !== 16'hFFFF)
            begin n_fail++; $display("FAIL wrap_packet got cyc=%0d op=%h imm=%h pc=%h want 2 3E 0012 FFFF", cyc, out_opcode, out_imm, out_pc); end
        n_chk++; if (mem_addr !== 16'h0001) begin n_fail++; $display("FAIL wrap_pc got %h want 0001", mem_addr); end
    endtask

    task automatic test_illegal;
        int cyc;
        mem[16'h0500] = 8'hD3;
        start_at(16'h0500);
        wait_valid(cyc);
        n_chk++; if (cyc !== 1 || out_illegal !== 1'b1 || out_len !== 2'd1 || out_opcode !== 8'hD3)
            begin n_fail++; $display("FAIL illegal_d3 got cyc=%0d ill=%b len=%0d op=%h want 1 1 1 D3", cyc, out_illegal, out_len, out_opcode); end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [15:0] got_pc [3];
        int          got_t  [3];
        mem[16'h0600] = 8'h3E; mem[16'h0601] = 8'h11; mem[16'h0602] = 8'h00;
        mem[16'h0603] = 8'h01; mem[16'h0604] = 8'h22; mem[16'h0605] = 8'h33;
        mem[16'h0606] = 8'h00;
        start_at(16'h0600);
        out_ready = 1'b1;
        n = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (n < 3) begin got_pc[n] = out_pc; got_t[n] = i; end
                n++;
            end
        end
        out_ready = 1'b0;
        n_chk++; if (n !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", n); end
        if (n >= 3) begin
            n_chk++; if (got_pc[0] !== 16'h0600 || got_pc[1] !== 16'h0602 || got_pc[2] !== 16'h0603)
                begin n_fail++; $display("FAIL b2b_pcs got %h %h %h want 0600 0602 0603", got_pc[0], got_pc[1], got_pc[2]); end
            n_chk++; if (got_t[0] !== 2 || got_t[1] !== 4 || got_t[2] !== 8)
                begin n_fail++; $display("FAIL b2b_timing got %0d %0d %0d want 2 4 8", got_t[0], got_t[1], got_t[2]); end
        end
    endtask

    task automatic test_reset_mid;
        start_at(16'h0100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0 || out_opcode !== 8'h00 || out_imm !== 16'h0000 || out_len !== 2'd0 || mem_addr !== 16'h0000)
            begin n_fail++; $display("FAIL rstmid_state got v=%b op=%h imm=%h len=%0d addr=%h want 0 00 0000 0 0000", out_valid, out_opcode, out_imm, out_len, mem_addr); end
        rst = 1'b0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (out_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0000)
            begin n_fail++; $display("FAIL rstmid_nopkt got v=%b rd=%b addr=%h want 0 1 0000", out_valid, mem_rd, mem_addr); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; xfer_cnt = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset;
        test_jp;
        test_cb;
        test_stall_and_hold;
        test_redirect;
        test_wrap;
        test_illegal;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
